// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline run/step/halt controller
// and its stage-enable sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_FILL   = 3'd2,
    ST_RUN    = 3'd3,
    ST_STOP   = 3'd4,
    ST_DRAIN  = 3'd5
  } state_t;

  typedef enum logic {
    MODE_RUN  = 1'b0,
    MODE_STEP = 1'b1
  } mode_t;

  localparam logic [1:0] CAUSE_RUNDROP  = 2'd0;
  localparam logic [1:0] CAUSE_STEPDONE = 2'd1;
  localparam logic [1:0] CAUSE_HALT     = 2'd2;
  localparam logic [1:0] CAUSE_BRK      = 2'd3;

  localparam logic [3:0] SEQ_EMPTY = 4'b0000;
  localparam logic [3:0] SEQ_FULL  = 4'b1111;

endpackage

// File: rtl/pipe_run_ctrl.sv
// Run/step/halt controller: turns debug commands into one-cycle start/stop
// requests for the stage-enable sequencer and reports how each run ended.
module pipe_run_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int STEP_W = 8
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              run_req,
  input  logic              step_req,
  input  logic              halt_req,
  input  logic              brk_hit,
  input  logic [STEP_W-1:0] step_len,
  input  logic [3:0]        stage_q,
  output logic              start,
  output logic              stop,
  output logic              busy,
  output logic              running,
  output logic              done,
  output logic [1:0]        halt_cause,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [2:0]        state_o
);

  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  state_t              r_state;
  state_t              w_state_next;
  mode_t               r_mode;
  logic                r_pend;
  logic [1:0]          r_pend_cause;
  logic [STEP_W-1:0]   r_rem;
  logic [CNT_W-1:0]    r_cycle_cnt;
  logic [1:0]          r_halt_cause;
  logic                r_done;

  logic                w_launch;
  logic                w_stop_cond;
  logic [1:0]          w_stop_cause;
  logic                w_fill_to_stop;
  logic [1:0]          w_fill_cause;
  logic                w_run_exit;
  logic [1:0]          w_run_cause;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next   = r_state;
    w_launch       = 1'b0;
    w_stop_cond    = 1'b0;
    w_stop_cause   = CAUSE_RUNDROP;
    w_fill_to_stop = 1'b0;
    w_fill_cause   = CAUSE_RUNDROP;
    w_run_exit     = 1'b0;
    w_run_cause    = CAUSE_RUNDROP;

    // Halt conditions shared by the fill-pending path and the RUN exit path
    if (brk_hit) begin
      w_stop_cond  = 1'b1;
      w_stop_cause = CAUSE_BRK;
    end else if (halt_req) begin
      w_stop_cond  = 1'b1;
      w_stop_cause = CAUSE_HALT;
    end else if (r_mode == MODE_RUN && !run_req) begin
      w_stop_cond  = 1'b1;
      w_stop_cause = CAUSE_RUNDROP;
    end

    case (r_state)
      ST_IDLE: begin
        if (stage_q == SEQ_EMPTY && (step_req || run_req)) begin
          w_launch     = 1'b1;
          w_state_next = ST_LAUNCH;
        end
      end
      ST_LAUNCH: w_state_next = ST_FILL;
      ST_FILL: begin
        if (stage_q == SEQ_FULL) begin
          if (r_pend || w_stop_cond) begin
            w_fill_to_stop = 1'b1;
            w_fill_cause   = r_pend ? r_pend_cause : w_stop_cause;
            w_state_next   = ST_STOP;
          end else begin
            w_state_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (brk_hit || halt_req) begin
          w_run_exit  = 1'b1;
          w_run_cause = w_stop_cause;
        end else if (r_mode == MODE_STEP && r_rem == STEP_ONE) begin
          w_run_exit  = 1'b1;
          w_run_cause = CAUSE_STEPDONE;
        end else if (r_mode == MODE_RUN && !run_req) begin
          w_run_exit  = 1'b1;
          w_run_cause = CAUSE_RUNDROP;
        end
        if (w_run_exit) w_state_next = ST_STOP;
      end
      ST_STOP: w_state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (stage_q == SEQ_EMPTY) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_mode       <= MODE_RUN;
      r_pend       <= 1'b0;
      r_pend_cause <= CAUSE_RUNDROP;
      r_rem        <= '0;
      r_cycle_cnt  <= '0;
      r_halt_cause <= CAUSE_RUNDROP;
      r_done       <= 1'b0;
    end else begin
      r_done <= (r_state == ST_DRAIN) && (w_state_next == ST_IDLE);
      if (w_launch) begin
        r_mode       <= step_req ? MODE_STEP : MODE_RUN;
        r_rem        <= (step_len == '0) ? STEP_ONE : step_len;
        r_cycle_cnt  <= '0;
        r_halt_cause <= CAUSE_RUNDROP;
        r_pend       <= 1'b0;
        r_pend_cause <= CAUSE_RUNDROP;
      end
      // First halt condition seen while filling is remembered until FULL
      if ((r_state == ST_LAUNCH || r_state == ST_FILL) && w_stop_cond && !r_pend) begin
        r_pend       <= 1'b1;
        r_pend_cause <= w_stop_cause;
      end
      if (w_fill_to_stop) r_halt_cause <= w_fill_cause;
      if (r_state == ST_RUN) begin
        r_cycle_cnt <= r_cycle_cnt + CNT_ONE;
        if (w_run_exit)              r_halt_cause <= w_run_cause;
        else if (r_mode == MODE_STEP) r_rem       <= r_rem - STEP_ONE;
      end
    end
  end

  assign start      = (r_state == ST_LAUNCH);
  assign stop       = (r_state == ST_STOP);
  assign busy       = (r_state != ST_IDLE);
  assign running    = (r_state == ST_RUN);
  assign done       = r_done;
  assign halt_cause = r_halt_cause;
  assign cycle_cnt  = r_cycle_cnt;
  assign state_o    = r_state;

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Directed bench: the controller paired with a behavioural stage-enable
// sequencer, checked against hand-derived timelines.
module tb_pipe_run_ctrl;
  import pipe_ctrl_pkg::*;

  logic        CLK;
  logic        RSTN;
  logic        run_req, step_req, halt_req, brk_hit;
  logic [7:0]  step_len;
  logic [3:0]  stage_q;
  logic        start, stop, busy, running, done;
  logic [1:0]  halt_cause;
  logic [31:0] cycle_cnt;
  logic [2:0]  state_o;

  logic        seq_fill, seq_drain;
  int          checks   = 0;
  int          failures = 0;
  bit          saw_run;

  pipe_run_ctrl #(.CNT_W(32), .STEP_W(8)) dut (
    .CLK(CLK), .RSTN(RSTN), .run_req(run_req), .step_req(step_req),
    .halt_req(halt_req), .brk_hit(brk_hit), .step_len(step_len),
    .stage_q(stage_q), .start(start), .stop(stop), .busy(busy),
    .running(running), .done(done), .halt_cause(halt_cause),
    .cycle_cnt(cycle_cnt), .state_o(state_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Thermometer sequencer: shifts ones in after start, zeros in after stop
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      stage_q   <= 4'b0000;
      seq_fill  <= 1'b0;
      seq_drain <= 1'b0;
    end else if (seq_fill) begin
      stage_q <= {stage_q[2:0], 1'b1};
      if (stage_q == 4'b0111) seq_fill <= 1'b0;
    end else if (seq_drain) begin
      stage_q <= {stage_q[2:0], 1'b0};
      if (stage_q == 4'b1000) seq_drain <= 1'b0;
    end else if (start && stage_q == 4'b0000) begin
      stage_q  <= 4'b0001;
      seq_fill <= 1'b1;
    end else if (stop && stage_q == 4'b1111) begin
      stage_q   <= 4'b1110;
      seq_drain <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st, input logic [3:0] stg);
    bit found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (state_o == st && stage_q == stg) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    if (!found) chk({tag, " timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_done(input string tag);
    bit found = 1'b0;
    saw_run = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (running) saw_run = 1'b1;
      if (done) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    if (!found) chk({tag, " done timeout"}, 32'd0, 32'd1);
  endtask

  task automatic launch_step(input logic [7:0] len);
    step_len = len;
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
  endtask

  initial begin
    logic [15:0] st_mask, sp_mask, dn_mask;
    RSTN = 1'b0; run_req = 1'b0; step_req = 1'b0; halt_req = 1'b0;
    brk_hit = 1'b0; step_len = 8'd0;
    #12;
    chk("reset outs", {22'd0, start, stop, busy, running, done, halt_cause, state_o}, 32'd0);
    chk("reset cnt", cycle_cnt, 32'd0);
    RSTN = 1'b1;
    tick();

    // Step of 3: cycle k is the cycle following edge k-1
    st_mask = '0; sp_mask = '0; dn_mask = '0;
    launch_step(8'd3);
    for (int k = 1; k <= 14; k++) begin
      st_mask[k] = start;
      sp_mask[k] = stop;
      dn_mask[k] = done;
      if (k < 14) tick();
    end
    chk("step3 start timing", {16'd0, st_mask}, 32'h0002);
    chk("step3 stop timing",  {16'd0, sp_mask}, 32'h0200);
    chk("step3 done timing",  {16'd0, dn_mask}, 32'h4000);
    chk("step3 cnt", cycle_cnt, 32'd3);
    chk("step3 cause", {30'd0, halt_cause}, {30'd0, CAUSE_STEPDONE});
    tick();
    chk("step3 done pulse", {31'd0, done}, 32'd0);

    // Free run: 10 RUN cycles with run_req high, drop seen in the 11th
    run_req = 1'b1;
    wait_state("run enter", ST_RUN, 4'b1111);
    for (int i = 0; i < 10; i++) tick();
    run_req = 1'b0;
    wait_done("run");
    chk("run cnt", cycle_cnt, 32'd11);
    chk("run cause", {30'd0, halt_cause}, {30'd0, CAUSE_RUNDROP});
    chk("run stage at done", {28'd0, stage_q}, 32'd0);
    tick();
    chk("run idle after", {31'd0, busy}, 32'd0);

    // Halt while filling goes straight to STOP
    launch_step(8'd5);
    wait_state("fill 0011", ST_FILL, 4'b0011);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    wait_done("fill halt");
    chk("fill halt no run", {31'd0, saw_run}, 32'd0);
    chk("fill halt cnt", cycle_cnt, 32'd0);
    chk("fill halt cause", {30'd0, halt_cause}, {30'd0, CAUSE_HALT});
    tick();

    // Breakpoint and halt together in the third RUN cycle
    launch_step(8'd20);
    wait_state("brk run", ST_RUN, 4'b1111);
    tick(); tick();
    brk_hit = 1'b1; halt_req = 1'b1;
    tick();
    brk_hit = 1'b0; halt_req = 1'b0;
    chk("brk state", {29'd0, state_o}, {29'd0, ST_STOP});
    chk("brk stop out", {31'd0, stop}, 32'd1);
    wait_done("brk");
    chk("brk cnt", cycle_cnt, 32'd3);
    chk("brk cause", {30'd0, halt_cause}, {30'd0, CAUSE_BRK});
    tick();

    // Zero length behaves as one
    launch_step(8'd0);
    wait_done("step0");
    chk("step0 cnt", cycle_cnt, 32'd1);
    chk("step0 cause", {30'd0, halt_cause}, {30'd0, CAUSE_STEPDONE});
    tick();

    // Asynchronous reset mid-drain, then a normal step
    launch_step(8'd4);
    wait_state("drain 1100", ST_DRAIN, 4'b1100);
    RSTN = 1'b0;
    #2;
    chk("rst drain outs", {22'd0, start, stop, busy, running, done, halt_cause, state_o}, 32'd0);
    chk("rst drain cnt", cycle_cnt, 32'd0);
    chk("rst drain stage", {28'd0, stage_q}, 32'd0);
    #3;
    RSTN = 1'b1;
    tick();
    launch_step(8'd2);
    chk("post rst launch", {29'd0, state_o}, {29'd0, ST_LAUNCH});
    wait_done("post rst");
    chk("post rst cnt", cycle_cnt, 32'd2);
    chk("post rst cause", {30'd0, halt_cause}, {30'd0, CAUSE_STEPDONE});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_run_ctrl.md
Name: pipe_run_ctrl

Overview:
- Run/step/halt controller for the pipeline stage-enable sequencer, which holds a 4-bit thermometer code: fill 0000→0001→0011→0111→1111, drain 1111→1110→1100→1000→0000.
- Converts debug/front-panel commands (free run, N-cycle single-step, halt, breakpoint) into the sequencer's one-cycle start/stop requests.
- Tracks the sequencer's progress, counts full-pipeline run cycles and reports why each run ended.
- Sits between the debug interface and the sequencer, on the same clock and reset.

Parameters:
- CNT_W, 32, width of the run-cycle counter.
- STEP_W, 8, width of the step-length input and the remaining-step counter.

Ports:
- CLK  in  1  clock, rising edge.
- RSTN  in  1  reset, asynchronous, active-low.
- run_req  in  1  level; free-run requested while high.
- step_req  in  1  pulse; start a step of step_len cycles.
- halt_req  in  1  pulse; request halt.
- brk_hit  in  1  pulse; breakpoint match from the pipeline.
- step_len  in  STEP_W  step length in RUN cycles, sampled when the step is launched.
- stage_q  in  4  sequencer thermometer state.
- start  out  1  to sequencer; accepted only when stage_q=0000.
- stop  out  1  to sequencer; accepted only when stage_q=1111.
- busy  out  1  high whenever state≠IDLE.
- running  out  1  high when state=RUN.
- done  out  1  one-cycle pulse when a run ends.
- halt_cause  out  2  why the run ended (codes under Behaviour); held until the next launch.
- cycle_cnt  out  CNT_W  RUN cycles in the current or last run.
- state_o  out  3  encoded FSM state, for debug.

Behaviour:
- Reset (async, RSTN=0) forces state=IDLE and clears mode, pending, rem, cycle_cnt, halt_cause and done to 0. All outputs read 0 during and after reset. The sequencer shares RSTN, so both return to 0000/IDLE together, including mid-operation.
- FSM states and encodings: IDLE=0, LAUNCH=1, FILL=2, RUN=3, STOP=4, DRAIN=5. start=1 only in LAUNCH; stop=1 only in STOP; both are Moore outputs.
- IDLE → LAUNCH when stage_q=0000 and (step_req or run_req).
  - step_req wins over run_req: mode=STEP, rem=max(step_len,1).
  - Otherwise mode=RUN.
  - On entry: cycle_cnt=0, halt_cause=0, pending cleared.
  - If stage_q≠0000, stay in IDLE and ignore requests.
- LAUNCH → FILL unconditionally after 1 cycle.
- FILL waits for stage_q=1111.
  - If pending is set → STOP directly (cycle_cnt stays 0).
  - Else → RUN.
- Pending during LAUNCH/FILL is set by any of:
  - brk_hit → cause 3;
  - halt_req → cause 2;
  - run_req=0 in RUN mode → cause 0.
- RUN: each cycle increments cycle_cnt (wraps modulo 2^CNT_W). Exit to STOP, with cause priority:
  - brk_hit → 3;
  - halt_req → 2;
  - STEP mode and rem=1 → 1;
  - RUN mode and run_req=0 → 0.
  - Otherwise stay; in STEP mode rem decrements.
  - The RUN cycle in which the exit condition is seen is still counted. STEP mode therefore yields exactly max(step_len,1) RUN cycles.
- STOP → DRAIN after 1 cycle (sequencer is at 1111 and accepts stop).
- DRAIN → IDLE when stage_q=0000. done=1 in the first IDLE cycle only.
- Ignored inputs:
  - halt_req/brk_hit during STOP/DRAIN.
  - step_req/run_req outside IDLE.
  - run_req still high in IDLE relaunches immediately after done.
- Nominal step timeline, step_len=3, step_req sampled at edge 0:
  - LAUNCH e1; FILL e2–e5 (stage_q reaches 1111 at e5); RUN e6–e8; STOP e9; DRAIN e10–e13; IDLE with done=1 at e14.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state enum and encodings;
  - halt_cause codes (RUNDROP=0, STEPDONE=1, HALT=2, BRK=3);
  - thermometer constants SEQ_EMPTY=4'b0000 and SEQ_FULL=4'b1111.
- No sub-module; a single FSM plus two counters.
- Bench pairs the block with the stage-enable sequencer (start/stop wired, stage_q fed back).

Test Plan:
- step_req, step_len=3 from reset-idle → start high at e1 only, stop high at e9 only, done at e14, cycle_cnt=3, halt_cause=1.
- run_req high for 10 cycles after RUN entry then low → cycle_cnt=10 ±(drop-edge alignment; check exact value), halt_cause=0, stage_q returns to 0000 before done.
- halt_req during FILL (stage_q=0011) → FILL→STOP directly, no RUN cycle, cycle_cnt=0, halt_cause=2.
- brk_hit and halt_req in the same RUN cycle → halt_cause=3, STOP on next edge.
- step_len=0 → exactly 1 RUN cycle, cycle_cnt=1, halt_cause=1.
- RSTN low during DRAIN (stage_q=1100) → immediately IDLE, all outputs 0; next step_req runs normally.
